rtp_audio_depack: RTL and testbench

Receive-side counterpart of the RTP audio packetizer. Consumes the byte stream delivered by the UDP receive path (`udp_rec_*`) and validates the 12-byte RTP header. Extracts big-endian 16-bit PCM samples into a sample FIFO and serves them to the WM8731 playback path (`wav_out_data`/`wav_rden`) with prefill, underrun and overflow handling. It sits between `ethernet_test` and `mywav` in the audio loop top.

---
 rtl/rtp_pkg.sv | 23 ++
 rtl/audio_sample_fifo.sv | 48 ++++
 rtl/rtp_audio_depack.sv | 190 +++++++++++++++++++
 tb/tb_rtp_audio_depack.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rtp_pkg.sv
// Constants and state encodings shared by the RTP audio packetizer and depacketizer.
package rtp_pkg;

  localparam int unsigned RTP_HDR_BYTES = 12;
  localparam logic [7:0]  RTP_M_MASK    = 8'h80;

  typedef enum logic [3:0] {
    R_IDLE = 4'b0001,
    R_HDR  = 4'b0010,
    R_PAY  = 4'b0100,
    R_DROP = 4'b1000
  } rx_state_e;

  typedef enum logic [1:0] {
    P_FILL = 2'b01,
    P_PLAY = 2'b10
  } pb_state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// 16-bit synchronous sample FIFO; read data is registered on pop.
module audio_sample_fifo #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [15:0]   wdata,
  input  logic          pop,
  output logic [15:0]   rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] DEPTH = (AW + 1)'(2 ** AW);

  logic [15:0]   mem [2 ** AW];
  logic [AW:0]   wr_q, rd_q;
  logic          push_ok, pop_ok;

  assign level = wr_q - rd_q;
  assign full  = (level == DEPTH);
  assign empty = (level == '0);

  // A pop frees the slot the push needs, so a full FIFO still accepts a push with a pop.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      rdata <= 16'h0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok) begin
        rd_q  <= rd_q + 1'b1;
        rdata <= mem[rd_q[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/rtp_audio_depack.sv
// RTP audio depacketizer: validates the RTP header from the UDP byte stream and
// feeds big-endian PCM samples through a FIFO to the playback path.
module rtp_audio_depack
  import rtp_pkg::*;
#(
  parameter logic [15:0] RTP_HEADER_PARAM = 16'h8080,
  parameter logic [31:0] SSRC             = 32'h12345678,
  parameter int unsigned FIFO_AW          = 10,
  parameter int unsigned PREFILL          = 512,
  parameter int unsigned BYTE_TIMEOUT     = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               udp_rec_data_valid,
  input  logic [7:0]         udp_rec_rdata,
  input  logic [15:0]        udp_rec_data_length,
  input  logic               wav_rden,
  output logic [15:0]        wav_out_data,
  output logic               playing,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [15:0]        pkt_ok_cnt,
  output logic [15:0]        pkt_drop_cnt,
  output logic [15:0]        seq_gap_cnt,
  output logic [15:0]        underrun_cnt,
  output logic [15:0]        overflow_cnt
);

  localparam int unsigned      TW       = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [TW-1:0]    TMO_LAST = TW'(BYTE_TIMEOUT - 1);
  localparam logic [15:0]      HDR_LEN  = 16'(RTP_HDR_BYTES);
  localparam logic [FIFO_AW:0] PF_LVL   = (FIFO_AW + 1)'(PREFILL);

  rx_state_e     r_state_q;
  pb_state_e     p_state_q;
  logic [15:0]   idx_q, len_q, seq_q, exp_seq_q;
  logic          exp_valid_q, bad_q, zero_q;
  logic [7:0]    msb_q;
  logic [TW-1:0] tmo_q;

  logic [7:0]    exp_byte, byte_mask;
  logic          byte_bad, hdr_bad, last, push, pop, full, empty;
  logic [15:0]   fifo_rdata;

  // Expected header byte at the current index; unchecked bytes have an empty mask.
  always_comb begin
    exp_byte  = 8'h0;
    byte_mask = 8'h0;
    case (idx_q)
      16'd0:  begin exp_byte = RTP_HEADER_PARAM[15:8]; byte_mask = 8'hFF;        end
      16'd1:  begin exp_byte = RTP_HEADER_PARAM[7:0];  byte_mask = ~RTP_M_MASK;  end
      16'd8:  begin exp_byte = SSRC[31:24];            byte_mask = 8'hFF;        end
      16'd9:  begin exp_byte = SSRC[23:16];            byte_mask = 8'hFF;        end
      16'd10: begin exp_byte = SSRC[15:8];             byte_mask = 8'hFF;        end
      16'd11: begin exp_byte = SSRC[7:0];              byte_mask = 8'hFF;        end
      default: ;
    endcase
  end

  assign byte_bad = |((udp_rec_rdata ^ exp_byte) & byte_mask);
  assign hdr_bad  = bad_q | byte_bad;
  assign last     = (idx_q == len_q - 16'd1);
  assign push     = (r_state_q == R_PAY) && udp_rec_data_valid && idx_q[0];
  assign pop      = (p_state_q == P_PLAY) && wav_rden && !empty;

  audio_sample_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({msb_q, udp_rec_rdata}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q    <= R_IDLE;
      idx_q        <= 16'd0;
      len_q        <= 16'd0;
      seq_q        <= 16'd0;
      exp_seq_q    <= 16'd0;
      exp_valid_q  <= 1'b0;
      bad_q        <= 1'b0;
      msb_q        <= 8'h0;
      tmo_q        <= '0;
      pkt_ok_cnt   <= 16'd0;
      pkt_drop_cnt <= 16'd0;
      seq_gap_cnt  <= 16'd0;
      overflow_cnt <= 16'd0;
    end else begin
      if (push && full && !pop) overflow_cnt <= sat_inc(overflow_cnt);
      case (r_state_q)
        R_IDLE: begin
          if (udp_rec_data_valid) begin
            len_q <= udp_rec_data_length;
            bad_q <= byte_bad;
            tmo_q <= '0;
            if (udp_rec_data_length <= 16'd1) begin
              pkt_drop_cnt <= sat_inc(pkt_drop_cnt);
            end else begin
              idx_q     <= 16'd1;
              // Odd total length means an odd payload as the header is even.
              r_state_q <= (udp_rec_data_length < HDR_LEN || udp_rec_data_length[0]) ?
                           R_DROP : R_HDR;
            end
          end
        end
        default: begin
          if (udp_rec_data_valid) begin
            tmo_q <= '0;
            idx_q <= last ? 16'd0 : idx_q + 16'd1;
            case (r_state_q)
              R_HDR: begin
                bad_q <= hdr_bad;
                if (idx_q == 16'd2) seq_q[15:8] <= udp_rec_rdata;
                if (idx_q == 16'd3) seq_q[7:0]  <= udp_rec_rdata;
                if (idx_q == HDR_LEN - 16'd1) begin
                  if (!hdr_bad) begin
                    if (exp_valid_q && seq_q != exp_seq_q) seq_gap_cnt <= sat_inc(seq_gap_cnt);
                    exp_seq_q   <= seq_q + 16'd1;
                    exp_valid_q <= 1'b1;
                    if (last) pkt_ok_cnt <= sat_inc(pkt_ok_cnt);
                    r_state_q <= last ? R_IDLE : R_PAY;
                  end else begin
                    if (last) pkt_drop_cnt <= sat_inc(pkt_drop_cnt);
                    r_state_q <= last ? R_IDLE : R_DROP;
                  end
                end
              end
              R_PAY: begin
                if (!idx_q[0]) msb_q <= udp_rec_rdata;
                if (last) begin
                  pkt_ok_cnt <= sat_inc(pkt_ok_cnt);
                  r_state_q  <= R_IDLE;
                end
              end
              R_DROP: begin
                if (last) begin
                  pkt_drop_cnt <= sat_inc(pkt_drop_cnt);
                  r_state_q    <= R_IDLE;
                end
              end
              default: ;
            endcase
          end else if (tmo_q == TMO_LAST) begin
            pkt_drop_cnt <= sat_inc(pkt_drop_cnt);
            idx_q        <= 16'd0;
            r_state_q    <= R_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
      endcase
    end
  end

  // zero_q selects silence instead of the FIFO read register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_state_q    <= P_FILL;
      zero_q       <= 1'b1;
      underrun_cnt <= 16'd0;
    end else begin
      unique case (p_state_q)
        P_FILL: begin
          if (wav_rden) zero_q <= 1'b1;
          if (fifo_level >= PF_LVL) p_state_q <= P_PLAY;
        end
        P_PLAY: begin
          if (wav_rden) begin
            zero_q <= empty;
            if (empty) begin
              underrun_cnt <= sat_inc(underrun_cnt);
              p_state_q    <= P_FILL;
            end
          end
        end
        default: p_state_q <= P_FILL;
      endcase
    end
  end

  assign wav_out_data = zero_q ? 16'h0 : fifo_rdata;
  assign playing      = (p_state_q == P_PLAY);

endmodule

// File: tb/tb_rtp_audio_depack.sv
// Scoreboard bench for rtp_audio_depack with a small FIFO, low prefill and short timeout.
module tb_rtp_audio_depack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        udp_rec_data_valid = 1'b0;
  logic [7:0]  udp_rec_rdata = 8'h0;
  logic [15:0] udp_rec_data_length = 16'h0;
  logic        wav_rden = 1'b0;
  logic [15:0] wav_out_data;
  logic        playing;
  logic [3:0]  fifo_level;
  logic [15:0] pkt_ok_cnt, pkt_drop_cnt, seq_gap_cnt, underrun_cnt, overflow_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];
  logic [7:0]  pkt[$];

  always #5 clk = ~clk;

  rtp_audio_depack #(
    .FIFO_AW      (3),
    .PREFILL      (4),
    .BYTE_TIMEOUT (32)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .udp_rec_data_valid  (udp_rec_data_valid),
    .udp_rec_rdata       (udp_rec_rdata),
    .udp_rec_data_length (udp_rec_data_length),
    .wav_rden            (wav_rden),
    .wav_out_data        (wav_out_data),
    .playing             (playing),
    .fifo_level          (fifo_level),
    .pkt_ok_cnt          (pkt_ok_cnt),
    .pkt_drop_cnt        (pkt_drop_cnt),
    .seq_gap_cnt         (seq_gap_cnt),
    .underrun_cnt        (underrun_cnt),
    .overflow_cnt        (overflow_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic build(input logic [15:0] seq, input logic [31:0] ssrc, input logic [7:0] b0,
                       input logic [7:0] b1, input int nsamp, input logic [15:0] base,
                       input logic [15:0] step);
    logic [15:0] s;
    pkt.delete();
    pkt.push_back(b0);
    pkt.push_back(b1);
    pkt.push_back(seq[15:8]);
    pkt.push_back(seq[7:0]);
    pkt.push_back(8'hDE); pkt.push_back(8'hAD); pkt.push_back(8'hBE); pkt.push_back(8'hEF);
    pkt.push_back(ssrc[31:24]); pkt.push_back(ssrc[23:16]);
    pkt.push_back(ssrc[15:8]);  pkt.push_back(ssrc[7:0]);
    s = base;
    for (int i = 0; i < nsamp; i++) begin
      pkt.push_back(s[15:8]);
      pkt.push_back(s[7:0]);
      s = s + step;
    end
  endtask

  // Sends the first nbytes of pkt with one idle cycle between strobes; wav_rden rides along
  // with byte rd_idx (-1 for none).
  task automatic send(input logic [15:0] len, input int nbytes, input int rd_idx);
    for (int i = 0; i < nbytes; i++) begin
      udp_rec_data_valid  = 1'b1;
      udp_rec_rdata       = pkt[i];
      udp_rec_data_length = len;
      wav_rden            = (i == rd_idx);
      cycles(1);
      udp_rec_data_valid  = 1'b0;
      wav_rden            = 1'b0;
      cycles(1);
    end
  endtask

  task automatic rd(input logic [15:0] exp);
    sb.push_back(exp);
    wav_rden = 1'b1;
    cycles(1);
    wav_rden = 1'b0;
    cycles(1);
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] ok, input logic [15:0] drop,
                         input logic [15:0] gap, input logic [15:0] und, input logic [15:0] ovf);
    chk({tag, "_ok"},   pkt_ok_cnt,   ok);
    chk({tag, "_drop"}, pkt_drop_cnt, drop);
    chk({tag, "_gap"},  seq_gap_cnt,  gap);
    chk({tag, "_und"},  underrun_cnt, und);
    chk({tag, "_ovf"},  overflow_cnt, ovf);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wav"},  wav_out_data, 16'h0);
    chk({tag, "_play"}, playing,      1'b0);
    chk({tag, "_lvl"},  fifo_level,   4'd0);
    chk_cnt(tag, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
  endtask

  initial begin
    fork
      begin : monitor
        logic pend;
        logic [15:0] e;
        forever begin
          @(posedge clk);
          pend = wav_rden && !rst;
          @(negedge clk);
          if (pend) begin
            checks++;
            if (sb.size() == 0) begin
              errors++;
              $display("FAIL sb_unexpected: got %0h, expected no read", wav_out_data);
            end else begin
              e = sb.pop_front();
              if (wav_out_data !== e) begin
                errors++;
                $display("FAIL sb_sample: got %0h, expected %0h", wav_out_data, e);
              end
            end
          end
        end
      end
    join_none

    cycles(3);
    rst = 1'b0;
    cycles(2);
    chk_zero("reset");

    // Request while filling with an empty FIFO: silence, no underrun.
    rd(16'h0);
    chk("fill_rd_und", underrun_cnt, 16'd0);

    // Valid packet seq 5, four samples; prefill of 4 reached.
    build(16'd5, 32'h12345678, 8'h80, 8'h80, 4, 16'h1122, 16'h2222);
    send(16'd20, 20, -1);
    cycles(3);
    chk("p1_lvl", fifo_level, 4'd4);
    chk("p1_play", playing, 1'b1);
    rd(16'h1122); rd(16'h3344); rd(16'h5566); rd(16'h7788); rd(16'h0);
    cycles(2);
    chk("p1_play_after", playing, 1'b0);
    chk("p1_lvl_after", fifo_level, 4'd0);
    chk_cnt("p1", 16'd1, 16'd0, 16'd0, 16'd1, 16'd0);

    // Sequence tracking: 6 in order (M bit clear), 8 skips, 0xFFFF skips, 0x0000 wraps cleanly.
    build(16'd6, 32'h12345678, 8'h80, 8'h00, 0, 16'h0, 16'h0);
    send(16'd12, 12, -1);
    cycles(2);
    chk("seq6_gap", seq_gap_cnt, 16'd0);
    build(16'd8, 32'h12345678, 8'h80, 8'h80, 0, 16'h0, 16'h0);
    send(16'd12, 12, -1);
    cycles(2);
    chk("seq8_gap", seq_gap_cnt, 16'd1);
    build(16'hFFFF, 32'h12345678, 8'h80, 8'h80, 0, 16'h0, 16'h0);
    send(16'd12, 12, -1);
    build(16'h0000, 32'h12345678, 8'h80, 8'h80, 0, 16'h0, 16'h0);
    send(16'd12, 12, -1);
    cycles(2);
    chk_cnt("seq", 16'd5, 16'd0, 16'd2, 16'd1, 16'd0);

    // Drops: wrong SSRC, odd payload; exp_seq must stay at 1.
    build(16'h0055, 32'h12345679, 8'h80, 8'h80, 1, 16'hDEAD, 16'h0);
    send(16'd14, 14, -1);
    build(16'd1, 32'h12345678, 8'h80, 8'h80, 1, 16'hBEEF, 16'h0);
    send(16'd13, 13, -1);
    cycles(2);
    chk("drop_lvl", fifo_level, 4'd0);
    build(16'd1, 32'h12345678, 8'h80, 8'h80, 0, 16'h0, 16'h0);
    send(16'd12, 12, -1);
    cycles(2);
    chk_cnt("drop", 16'd6, 16'd2, 16'd2, 16'd1, 16'd0);

    // Overflow: ten samples into depth 8, then push+pop while full.
    build(16'd2, 32'h12345678, 8'h80, 8'h80, 10, 16'hA000, 16'h0001);
    send(16'd32, 32, -1);
    cycles(2);
    chk("ovf_lvl", fifo_level, 4'd8);
    chk("ovf_cnt", overflow_cnt, 16'd2);
    chk("ovf_play", playing, 1'b1);
    build(16'd3, 32'h12345678, 8'h80, 8'h80, 1, 16'hB000, 16'h0);
    sb.push_back(16'hA000);
    send(16'd14, 14, 13);
    cycles(2);
    chk("full_pp_lvl", fifo_level, 4'd8);
    chk("full_pp_ovf", overflow_cnt, 16'd2);
    for (int i = 1; i < 8; i++) rd(16'hA000 + 16'(i));
    rd(16'hB000);
    rd(16'h0);
    cycles(2);
    chk("drain_play", playing, 1'b0);
    chk_cnt("ovf", 16'd8, 16'd2, 16'd2, 16'd2, 16'd2);

    // Timeout: 20 bytes of a 960-byte packet, then silence.
    build(16'd4, 32'h12345678, 8'h80, 8'h80, 4, 16'hC000, 16'h0001);
    send(16'd960, 20, -1);
    cycles(20);
    chk("tmo_early_drop", pkt_drop_cnt, 16'd2);
    cycles(20);
    chk("tmo_drop", pkt_drop_cnt, 16'd3);
    chk("tmo_lvl", fifo_level, 4'd4);
    build(16'd5, 32'h12345678, 8'h80, 8'h80, 0, 16'h0, 16'h0);
    send(16'd12, 12, -1);
    cycles(2);
    chk_cnt("tmo", 16'd9, 16'd3, 16'd2, 16'd2, 16'd2);

    // Reset mid-packet clears everything; next packet never counts a gap.
    build(16'd6, 32'h12345678, 8'h80, 8'h80, 4, 16'hD000, 16'h0001);
    send(16'd20, 5, -1);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(1);
    chk_zero("midrst");
    build(16'h0100, 32'h12345678, 8'h80, 8'h80, 0, 16'h0, 16'h0);
    send(16'd12, 12, -1);
    cycles(2);
    chk_cnt("postrst", 16'd1, 16'd0, 16'd0, 16'd0, 16'd0);

    cycles(2);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
